// File: rtl/oak_core.sv
// ---------------------------------------------------------------------------
// oak_core: two-phase (fetch/execute) register-machine core with flags, data
// RAM, conditional branches and halt.                              rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module oak_core #(
  parameter int DATA_W = 8,
  parameter int RAM_AW = 5,
  parameter int PC_W   = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              run,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [23:0]       imem_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JEQ  = 4'hD;
  localparam logic [3:0] OP_JNE  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t state, state_nxt;

  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] ram  [2**RAM_AW];
  logic [PC_W-1:0]   pc;

  logic [3:0]        op, rd, ra, rb;
  logic [7:0]        imm;
  logic [DATA_W-1:0] a_val, b_val, imm_ext, result;
  logic [DATA_W:0]   wide;
  logic              carry, wr_en, flag_en, exec;
  logic [PC_W-1:0]   pc_nxt;
  logic [RAM_AW-1:0] ram_addr;

  assign op        = imem_rdata[23:20];
  assign rd        = imem_rdata[19:16];
  assign ra        = imem_rdata[15:12];
  assign rb        = imem_rdata[11:8];
  assign imm       = imem_rdata[7:0];
  assign imm_ext   = DATA_W'(imm);
  assign ram_addr  = imm[RAM_AW-1:0];
  assign a_val     = regs[ra];
  assign b_val     = regs[rb];
  assign exec      = (state == S_EXEC);
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

  always_ff @(posedge sysclk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (run) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (op == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Result, write-enable and flag-enable decode for the instruction in EXEC.
  always_comb begin
    wide    = '0;
    result  = '0;
    carry   = 1'b0;
    wr_en   = 1'b0;
    flag_en = 1'b0;
    case (op)
      OP_LDI: begin result = imm_ext; wr_en = 1'b1; end
      OP_ADD: begin
        wide    = {1'b0, a_val} + {1'b0, b_val};
        result  = wide[DATA_W-1:0];
        carry   = wide[DATA_W];
        wr_en   = 1'b1;
        flag_en = 1'b1;
      end
      OP_SUB: begin
        wide    = {1'b0, a_val} - {1'b0, b_val};
        result  = wide[DATA_W-1:0];
        carry   = wide[DATA_W];
        wr_en   = 1'b1;
        flag_en = 1'b1;
      end
      OP_AND: begin result = a_val & b_val; wr_en = 1'b1; flag_en = 1'b1; end
      OP_OR:  begin result = a_val | b_val; wr_en = 1'b1; flag_en = 1'b1; end
      OP_XOR: begin result = a_val ^ b_val; wr_en = 1'b1; flag_en = 1'b1; end
      OP_NOT: begin result = ~a_val;        wr_en = 1'b1; flag_en = 1'b1; end
      OP_MOV: begin result = a_val;         wr_en = 1'b1; end
      OP_LD:  begin result = ram[ram_addr]; wr_en = 1'b1; end
      default: ;
    endcase
  end

  // HALT leaves pc on the HALT instruction itself.
  always_comb begin
    pc_nxt = pc + PC_W'(1);
    case (op)
      OP_JMP:  pc_nxt = imm[PC_W-1:0];
      OP_JEQ:  if (a_val == b_val) pc_nxt = imm[PC_W-1:0];
      OP_JNE:  if (a_val != b_val) pc_nxt = imm[PC_W-1:0];
      OP_HALT: pc_nxt = pc;
      default: ;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      pc         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (exec) begin
        pc <= pc_nxt;
        if (wr_en) regs[rd] <= result;
        if (flag_en) begin
          flag_z <= (result == '0);
          flag_c <= carry;
        end
        if (op == OP_OUT) begin
          dout       <= a_val;
          dout_valid <= 1'b1;
        end
      end
    end
  end

  // Data RAM carries no reset; a store in flight when reset hits is dropped.
  always_ff @(posedge sysclk) begin
    if (!reset && exec && (op == OP_ST)) ram[ram_addr] <= a_val;
  end

endmodule

`default_nettype wire

// File: tb/tb_oak_core.sv
// ---------------------------------------------------------------------------
// tb_oak_core: scoreboard bench for oak_core (8-bit/PC 8 and 16-bit/PC 4).
//                                                                  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_oak_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset1, run1, reset2, run2;
  logic [7:0]  addr1;
  logic [3:0]  addr2;
  logic [23:0] rdata1, rdata2;
  logic [7:0]  dout1;
  logic [15:0] dout2;
  logic        dv1, dv2, fz1, fc1, fz2, fc2, halt1, halt2;

  logic [23:0] rom1 [256];
  logic [23:0] rom2 [16];

  always @(posedge clk) rdata1 <= rom1[addr1];
  always @(posedge clk) rdata2 <= rom2[addr2];

  oak_core #(.DATA_W(8), .RAM_AW(5), .PC_W(8)) dut1 (
    .sysclk(clk), .reset(reset1), .run(run1),
    .imem_addr(addr1), .imem_rdata(rdata1),
    .dout(dout1), .dout_valid(dv1),
    .flag_z(fz1), .flag_c(fc1), .halted(halt1)
  );

  oak_core #(.DATA_W(16), .RAM_AW(5), .PC_W(4)) dut2 (
    .sysclk(clk), .reset(reset2), .run(run2),
    .imem_addr(addr2), .imem_rdata(rdata2),
    .dout(dout2), .dout_valid(dv2),
    .flag_z(fz2), .flag_c(fc2), .halted(halt2)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] q1[$];
  logic [15:0] q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [7:0] imm);
    return {op, rd, ra, rb, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every output strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (dv1 === 1'b1) begin
      if (q1.size() == 0) check("dout1_unexpected_pulse", {24'd0, dout1}, 32'hFFFF_FFFF);
      else                check("dout1", {24'd0, dout1}, {16'd0, q1.pop_front()});
    end
    if (dv2 === 1'b1) begin
      if (q2.size() == 0) check("dout2_unexpected_pulse", {16'd0, dout2}, 32'hFFFF_FFFF);
      else                check("dout2", {16'd0, dout2}, {16'd0, q2.pop_front()});
    end
  end

  task automatic wait_halt1(input int bound);
    int n = 0;
    while (halt1 !== 1'b1 && n < bound) begin tick(1); n++; end
    check("halt1_reached", {31'd0, halt1}, 32'd1);
  endtask

  int bad;

  initial begin
    reset1 = 1'b1; run1 = 1'b1; reset2 = 1'b1; run2 = 1'b1;
    for (int i = 0; i < 256; i++) rom1[i] = 24'h0;
    for (int i = 0; i < 16; i++)  rom2[i] = 24'h0;

    // Reset arriving during EXEC of LDI r1,0x55 must discard the write.
    rom1[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 8'h55);
    rom1[1] = enc(4'hF, 4'd0, 4'd0, 4'd0, 8'h00);
    tick(2);
    reset1 = 1'b0;
    tick(1);
    reset1 = 1'b1;
    tick(1);
    check("rst_imem_addr", {24'd0, addr1}, 32'h0);
    check("rst_dout",      {24'd0, dout1}, 32'h0);
    check("rst_flags",     {30'd0, fz1, fc1}, 32'h0);
    check("rst_halted",    {31'd0, halt1}, 32'h0);
    rom1[0] = enc(4'hB, 4'd0, 4'd1, 4'd0, 8'h00);   // OUT r1 exposes r1
    q1.push_back(16'h00);
    tick(1);
    reset1 = 1'b0;
    wait_halt1(20);

    // Arithmetic, flags, pause, branches, halt.
    reset1 = 1'b1;
    for (int i = 0; i < 256; i++) rom1[i] = 24'h0;
    rom1[8'h00] = enc(4'h1, 4'd1, 4'd0, 4'd0, 8'hF0);
    rom1[8'h01] = enc(4'h1, 4'd2, 4'd0, 4'd0, 8'h20);
    rom1[8'h02] = enc(4'h2, 4'd3, 4'd1, 4'd2, 8'h00);
    rom1[8'h03] = enc(4'hB, 4'd0, 4'd3, 4'd0, 8'h00);
    rom1[8'h04] = enc(4'h3, 4'd4, 4'd2, 4'd2, 8'h00);
    rom1[8'h05] = enc(4'h1, 4'd1, 4'd0, 4'd0, 8'h03);
    rom1[8'h06] = enc(4'h1, 4'd2, 4'd0, 4'd0, 8'h03);
    rom1[8'h07] = enc(4'hD, 4'd0, 4'd1, 4'd2, 8'h10);
    rom1[8'h10] = enc(4'hE, 4'd0, 4'd1, 4'd2, 8'h30);
    rom1[8'h11] = enc(4'h7, 4'd8, 4'd1, 4'd0, 8'h00);
    rom1[8'h12] = enc(4'hB, 4'd0, 4'd8, 4'd0, 8'h00);
    rom1[8'h13] = enc(4'hF, 4'd0, 4'd0, 4'd0, 8'h00);
    tick(2);
    reset1 = 1'b0;
    tick(6);
    check("add_flag_c", {31'd0, fc1}, 32'd1);
    check("add_flag_z", {31'd0, fz1}, 32'd0);
    run1 = 1'b0;
    tick(5);
    check("pause_imem_addr", {24'd0, addr1}, 32'h03);
    run1 = 1'b1;
    q1.push_back(16'h10);
    tick(4);
    check("sub_flags_zc", {30'd0, fz1, fc1}, 32'b10);
    tick(6);
    check("jeq_taken_addr", {24'd0, addr1}, 32'h10);
    tick(2);
    check("jne_fallthrough_addr", {24'd0, addr1}, 32'h11);
    q1.push_back(16'hFC);
    tick(4);
    check("not_flags_zc", {30'd0, fz1, fc1}, 32'b00);
    tick(2);
    check("halt_halted", {31'd0, halt1}, 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (addr1 !== 8'h13 || halt1 !== 1'b1) bad++;
    end
    check("halt_frozen_20_cycles", bad, 0);
    reset1 = 1'b1;
    tick(1);
    check("halt_reset_halted", {31'd0, halt1}, 32'd0);
    check("halt_reset_addr",   {24'd0, addr1}, 32'h0);

    // RAM round trip; OUT result strobes in cycle 9 after release.
    for (int i = 0; i < 256; i++) rom1[i] = 24'h0;
    rom1[0] = enc(4'h1, 4'd5, 4'd0, 4'd0, 8'hA5);
    rom1[1] = enc(4'hA, 4'd0, 4'd5, 4'd0, 8'h1F);
    rom1[2] = enc(4'h9, 4'd6, 4'd0, 4'd0, 8'h1F);
    rom1[3] = enc(4'hB, 4'd0, 4'd6, 4'd0, 8'h00);
    rom1[4] = enc(4'hF, 4'd0, 4'd0, 4'd0, 8'h00);
    q1.push_back(16'hA5);
    tick(1);
    reset1 = 1'b0;
    tick(7);
    check("ram_dv_cycle8_low", {31'd0, dv1}, 32'd0);
    tick(1);
    check("ram_dv_cycle9_high", {31'd0, dv1}, 32'd1);
    tick(1);
    check("ram_dv_cycle10_low", {31'd0, dv1}, 32'd0);
    wait_halt1(20);

    // 16-bit datapath and 4-bit PC wrap through JMP 0x00 from 0xF.
    rom2[0]  = enc(4'h1, 4'd1, 4'd0, 4'd0, 8'hF0);
    rom2[1]  = enc(4'h1, 4'd2, 4'd0, 4'd0, 8'h20);
    rom2[2]  = enc(4'h2, 4'd3, 4'd1, 4'd2, 8'h00);
    rom2[3]  = enc(4'hB, 4'd0, 4'd3, 4'd0, 8'h00);
    rom2[15] = enc(4'hC, 4'd0, 4'd0, 4'd0, 8'h00);
    q2.push_back(16'h0110);
    tick(1);
    reset2 = 1'b0;
    tick(8);
    check("w16_flags_zc", {30'd0, fz2, fc2}, 32'b00);
    check("w16_addr", {28'd0, addr2}, 32'h4);
    rom2[0] = enc(4'hF, 4'd0, 4'd0, 4'd0, 8'h00);
    tick(24);
    check("jmp_wrap_addr", {28'd0, addr2}, 32'h0);
    tick(2);
    check("w16_halted", {31'd0, halt2}, 32'd1);

    tick(2);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/oak_core.md
# oak_core

Parametrised successor to the fixed 8-bit opcode engine: a two-phase (fetch/execute) register-machine core. It fetches 24-bit instructions from an external synchronous program memory. It executes against an internal register file and data RAM, keeps zero/carry flags, supports conditional branches and a halt state, and reports results through an explicit output-valid strobe. It sits between the program ROM/flash image and the board-level output pins, and replaces the frame-driven datapath.

## Interface
- DATA_W, 8: register, RAM word and dout width (≥ 8).
- RAM_AW, 5: data RAM address width (≤ 8); depth = 2^RAM_AW.
- PC_W, 8: program counter width (≤ 8); program space = 2^PC_W words.

- sysclk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  when low, core holds in FETCH without advancing (pause).
- imem_addr  out  PC_W  program memory address (registered copy of pc).
- imem_rdata  in  24  instruction word; valid one cycle after imem_addr (synchronous ROM).
- dout  out  DATA_W  last value emitted by OUT.
- dout_valid  out  1  one-cycle pulse when dout is updated.
- flag_z, flag_c  out  1 each  zero / carry(borrow) flags.
- halted  out  1  high while in HALT.

## Operation
- Instruction fields: op = [23:20], rd = [19:16], ra = [15:12], rb = [11:8], imm = [7:0]. imm is zero-extended to DATA_W; truncated to PC_W for jumps and to RAM_AW for RAM addresses.
- 16 registers of DATA_W bits; data RAM has 2^RAM_AW words of DATA_W bits, with combinational read and synchronous write.
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd ← imm.
  - 2 ADD: rd ← ra + rb, C = carry out.
  - 3 SUB: rd ← ra − rb, C = borrow (ra < rb unsigned).
  - 4 AND, 5 OR, 6 XOR: rd ← ra op rb, C = 0.
  - 7 NOT: rd ← ~ra, C = 0.
  - 8 MOV: rd ← ra (flags untouched).
  - 9 LD: rd ← ram[imm].
  - A ST: ram[imm] ← ra.
  - B OUT: dout ← ra, pulse dout_valid.
  - C JMP: pc ← imm.
  - D JEQ: pc ← imm if ra == rb, else pc + 1.
  - E JNE: pc ← imm if ra != rb, else pc + 1.
  - F HALT.
- Flags update only on ops 2–7. Z = (result == 0). Arithmetic is modulo 2^DATA_W.
- Non-branch ops: pc ← pc + 1, wrapping modulo 2^PC_W (max address → 0).
- rd == ra or rd == rb is legal; operands are read before the write takes effect.
- State machine:
  - FETCH: when run = 1, go to EXEC; when run = 0, stay.
  - EXEC: decode imem_rdata, commit all writes, update pc. Go to HALT on op F, else to FETCH.
  - HALT: pc frozen, halted = 1; the only exit is reset.
- Reset values: pc = 0, imem_addr = 0, all 16 registers = 0, dout = 0, dout_valid = 0, flag_z = 0, flag_c = 0, halted = 0, state = FETCH. Data RAM is not cleared; its contents are undefined until written.

## Timing
- Each instruction takes 2 cycles (FETCH + EXEC) while run stays high; no pipelining or overlap.
- imem_addr changes only at the end of EXEC. It is stable throughout FETCH and EXEC of the same instruction.
- Register, RAM, flag, dout and pc writes all occur on the edge that ends EXEC. Results are visible to the next instruction.
- dout_valid is high for exactly the cycle after that edge, and low otherwise.
- run is sampled only in FETCH; deasserting run during EXEC does not abort the current instruction.
- reset = 1 at any edge overrides every other update at that edge, including writes from an in-flight EXEC, which are discarded. Fetch restarts at address 0 on the first cycle after reset is released.
- halted rises on the edge ending the HALT instruction's EXEC.

## Test plan
- Reset check: drive reset mid-EXEC of "LDI r1,0x55" -> r1 stays 0x00, imem_addr = 0, dout = 0, flags = 0, halted = 0 on the next cycle.
- Arithmetic and flags: LDI r1,0xF0; LDI r2,0x20; ADD r3,r1,r2; OUT r3 -> dout = 0x10 with a single dout_valid pulse, flag_c = 1, flag_z = 0. Then SUB r4,r2,r2 -> flag_z = 1, flag_c = 0.
- RAM round trip: LDI r5,0xA5; ST [0x1F],r5; LD r6,[0x1F]; OUT r6 -> dout = 0xA5, with dout_valid high on cycle 9 (4 instructions × 2 cycles).
- Branches: LDI r1,3; LDI r2,3; JEQ r1,r2,0x10 -> next imem_addr = 0x10. JNE with equal operands -> pc + 1. JMP 0x00 with PC_W = 4 from pc 0xF -> imem_addr = 0x0.
- Pause and halt: hold run = 0 for 5 cycles during FETCH -> imem_addr and registers unchanged. HALT -> halted = 1 and imem_addr frozen for 20 cycles; reset -> halted = 0, imem_addr = 0.
- Parameter sweep: rerun the arithmetic test with DATA_W = 16 -> 0x00F0 + 0x0020 = 0x0110, flag_c = 0.
